rs_enc_param: RTL
=================

# rs_enc_param

Parametrised systematic Reed-Solomon encoder over GF(2^SYM_W), NPAR parity symbols, codeword length N. It supersedes the fixed per-tap multiply/XOR stages with one complete LFSR encoder, a streaming valid/ready interface, and shortened-codeword support. It sits between the framer (message source) and the channel interleaver (codeword sink). It passes message symbols through unchanged, then appends NPAR parity symbols.

## Interface
- SYM_W, 8, symbol width in bits (field GF(2^SYM_W))
- PRIM_POLY, 'h11D, primitive field polynomial, SYM_W+1 bits
- N, 255, full codeword length in symbols; N <= 2^SYM_W - 1
- NPAR, 16, parity symbols per codeword; K = N - NPAR message symbols; NPAR >= 2
- FCR, 0, first consecutive root; g(x) = prod over i=0..NPAR-1 of (x + alpha^(FCR+i)), monic, alpha = 2
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_data  in  SYM_W  message symbol
- in_valid  in  1  in_data valid
- in_last  in  1  final message symbol of a shortened codeword; qualified by in_valid
- in_ready  out  1  encoder accepts in_data this cycle
- out_data  out  SYM_W  codeword symbol
- out_valid  out  1  out_data valid
- out_par  out  1  out_data is a parity symbol
- out_last  out  1  final parity symbol of the codeword
- out_ready  in  1  sink accepts out_data this cycle

## Operation
- Generator coefficients g[0..NPAR-1] are elaboration-time constants computed from PRIM_POLY, FCR and NPAR. No runtime multipliers use variable operands. All field multiplies are by constants, implemented as XOR networks.
- Parity register p[0..NPAR-1], each SYM_W bits. Msg counter cnt runs 0..K-1.
- States are MSG and PAR.
- MSG, on an accepted input (in_valid && in_ready):
  - fb = in_data ^ p[NPAR-1]
  - p[i] <= p[i-1] ^ gmul(fb, g[i]) for i >= 1
  - p[0] <= gmul(fb, g[0])
  - in_data is loaded into the output register with out_par=0
  - cnt increments
- If the accepted symbol has in_last=1, or cnt==K-1, the block goes to PAR and cnt is cleared.
- in_last with cnt < K-1 gives a shortened code, which is valid. in_last on the K-th symbol is identical to the plain case.
- PAR, each time the output register is free:
  - p[NPAR-1] is loaded into the output register with out_par=1
  - p[i] <= p[i-1], p[0] <= 0
  - parity counter increments
- On the NPAR-th parity, out_last=1 is loaded and the block returns to MSG. p is then all-zero.
- Output register is "free" when !out_valid || out_ready.
- in_ready = (state==MSG) && free.
- in_data is ignored when not accepted. in_last is ignored when in_valid=0.
- An empty message cannot occur: a codeword starts only on an accepted input.

## Timing
- Reset values:
  - out_valid=0, out_par=0, out_last=0, out_data=0
  - p all 0, cnt=0, state=MSG
  - in_ready=1 in the first cycle after reset release
- Latency: an accepted input appears on out_data the next cycle.
- Throughput is 1 symbol/cycle with out_ready held high.
  - No bubble between the last message symbol and the first parity.
  - No bubble between the last parity and the next codeword's first message symbol (in_ready is high in the cycle out_last is first presented).
- Stall: with out_valid=1 and out_ready=0, out_data/out_par/out_last, p, cnt and state hold. in_ready=0.
- out_valid drops the cycle after a transfer if no new symbol is loaded.
- in_ready is 0 for the entire PAR phase, for exactly NPAR output transfers.
- Asynchronous reset mid-codeword discards the partial codeword and parity immediately. The first post-reset input starts a new codeword at cnt=0.

## Test plan
- NPAR=2, default field and FCR, so g = {g1=0x03, g0=0x02}; K-1 zeros then 0x01 -> message echoed, then parity 0x03, 0x02, out_last on 0x02.
- Default RS(255,239), all-zero message of 239 symbols -> 239 zeros, then 16 zero parity with out_par=1. Exactly 255 beats, no gaps.
- Default config, random messages, out_ready randomised at 50% -> output matches the golden software encoder symbol-for-symbol. No drop or duplicate. Outputs stable while stalled.
- Shortened: NPAR=2, message 0x01 with in_last=1 as the first symbol -> out 0x01, then 0x03, 0x02. Next codeword accepted without a bubble.
- Back-to-back codewords with continuous in_valid -> in_ready low for exactly NPAR cycles per codeword. Parity of the second codeword is unaffected by the first.
- Assert rst low mid-message (cnt=100), release, send a full codeword -> out_valid=0 during reset. Post-reset parity equals the golden value for the new codeword alone.

Source files
------------

// File: rtl/rs_enc_param_if.sv
// Purpose : message-in / codeword-out stream bundle for the RS encoder.
// Latency : none (wires only).
// Backpressure: valid/ready on both sides; in_ready from encoder, out_ready from sink.
// Ports   : in_data/in_valid/in_last/in_ready (message side),
//           out_data/out_valid/out_par/out_last/out_ready (codeword side).
//           slave = encoder view, master = framer+interleaver view.
interface rs_enc_param_if #(
    parameter int SYM_W = 8
);
    logic [SYM_W-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [SYM_W-1:0] out_data;
    logic             out_valid;
    logic             out_par;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_par, out_last
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_par, out_last
    );
endinterface

// File: rtl/rs_enc_param.sv
// Purpose : systematic RS encoder over GF(2^SYM_W); echoes message symbols, then appends NPAR parity.
// Latency : 1 cycle from accepted input to out_data; 1 symbol/cycle when out_ready is held high.
// Backpressure: output register holds while out_valid && !out_ready; in_ready low then and for all of PAR.
// Ports   : clk, rst (async, active-low), io (rs_enc_param_if.slave) carrying
//           in_data/in_valid/in_last/in_ready and out_data/out_valid/out_par/out_last/out_ready.
module rs_enc_param #(
    parameter int          SYM_W     = 8,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int          N         = 255,
    parameter int          NPAR      = 16,
    parameter int          FCR       = 0
) (
    input  logic           clk,
    input  logic           rst,
    rs_enc_param_if.slave  io
);
    localparam int K      = N - NPAR;
    localparam int CNT_W  = $clog2(N);
    localparam int PCNT_W = $clog2(NPAR);

    typedef logic [SYM_W-1:0]            sym_t;
    typedef logic [NPAR-1:0][SYM_W-1:0]  par_t;
    typedef logic [NPAR:0][SYM_W-1:0]    poly_t;
    typedef enum logic { MSG, PAR } state_t;

    // Multiply by alpha (=2) modulo the field polynomial.
    function automatic sym_t xtime(input sym_t a);
        return a[SYM_W-1] ? ((a << 1) ^ SYM_W'(PRIM_POLY)) : (a << 1);
    endfunction

    // Shift-and-add field multiply. Every call site passes a constant b,
    // so each instance folds down to a fixed XOR network.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t r;
        r = '0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            r = xtime(r);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Expand prod (x + alpha^(FCR+i)); the monic x^NPAR term is implicit.
    function automatic par_t gen_poly();
        poly_t g;
        sym_t  root;
        root = sym_t'(1);
        for (int i = 0; i < FCR; i++) root = xtime(root);
        g    = '0;
        g[0] = sym_t'(1);
        for (int i = 0; i < NPAR; i++) begin
            for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = xtime(root);
        end
        return g[NPAR-1:0];
    endfunction

    localparam par_t G = gen_poly();

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PCNT_W-1:0] pcnt;
    par_t              p;
    par_t              p_msg;
    sym_t              fb;
    logic              free;

    assign free        = !io.out_valid || io.out_ready;
    assign io.in_ready = (state == MSG) && free;
    assign fb          = io.in_data ^ p[NPAR-1];

    // Next parity state for one message symbol (LFSR division step).
    always_comb begin
        p_msg    = '0;
        p_msg[0] = gf_mul(fb, G[0]);
        for (int i = 1; i < NPAR; i++) p_msg[i] = p[i-1] ^ gf_mul(fb, G[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= MSG;
            cnt          <= '0;
            pcnt         <= '0;
            p            <= '0;
            io.out_data  <= '0;
            io.out_valid <= 1'b0;
            io.out_par   <= 1'b0;
            io.out_last  <= 1'b0;
        end else if (free) begin
            unique case (state)
                MSG: begin
                    if (io.in_valid) begin
                        p            <= p_msg;
                        io.out_data  <= io.in_data;
                        io.out_valid <= 1'b1;
                        io.out_par   <= 1'b0;
                        io.out_last  <= 1'b0;
                        // in_last before K symbols shortens the codeword.
                        if (io.in_last || cnt == CNT_W'(K - 1)) begin
                            state <= PAR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        io.out_valid <= 1'b0;
                        io.out_par   <= 1'b0;
                        io.out_last  <= 1'b0;
                    end
                end
                PAR: begin
                    // Drain highest-degree parity first; zero-fill so p is clean for the next codeword.
                    io.out_data  <= p[NPAR-1];
                    io.out_valid <= 1'b1;
                    io.out_par   <= 1'b1;
                    p            <= {p[NPAR-2:0], sym_t'(0)};
                    if (pcnt == PCNT_W'(NPAR - 1)) begin
                        io.out_last <= 1'b1;
                        pcnt        <= '0;
                        state       <= MSG;
                    end else begin
                        io.out_last <= 1'b0;
                        pcnt        <= pcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
